// File: rtl/conv_psum_acc.sv
// Purpose: multi-pass convolution partial-sum accumulator (channel adder tree + per-pixel buffer + output FIFO).
// Latency: L+1 edges from beat acceptance to FIFO push (L = log2(InputDim)); out_valid follows one cycle later.
// Backpressure: in_ready low outside RUN and on the final pass when FIFO + in-flight beats would reach OutFifoDepth.
// Option: define CONV_PSUM_RELU_EN to clamp negative final-pass sums to zero before the FIFO push.

// Small synchronous FIFO, storage unreset.
// Latency: one edge from write to visibility at the head.
// Backpressure: a write is dropped only when full with no pop in the same cycle.
module conv_psum_fifo #(
    parameter int Width = 40,
    parameter int Depth = 8,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             wr_vld,
    input  logic [Width-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [Width-1:0] rd_dat,
    output logic [CntW-1:0]  cnt
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [0:Depth-1];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign rd_vld = (cnt != '0);
    assign do_rd  = rd_vld && rd_rdy;
    assign do_wr  = wr_vld && ((cnt != CntW'(Depth)) || do_rd);
    assign rd_dat = mem[rd_ptr];

    // Pointer and occupancy tracking; simultaneous push and pop leave cnt unchanged.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge Clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

module conv_psum_acc #(
    parameter int DataWidth    = 16,
    parameter int InputDim     = 8,
    parameter int AccWidth     = 40,
    parameter int AddrWidth    = 12,
    parameter int OutFifoDepth = 8
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          start,
    input  logic [AddrWidth:0]            cfg_pixels,
    input  logic [7:0]                    cfg_groups,
    input  logic signed [AccWidth-1:0]    bias_in,
    input  logic [InputDim*DataWidth-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [AccWidth-1:0]    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          ovf
);
    localparam int L    = $clog2(InputDim);
    localparam int CntW = $clog2(OutFifoDepth + 1);
    localparam logic [AddrWidth:0] PixOne = 1;
    localparam logic signed [AccWidth-1:0] AccMax = {1'b0, {(AccWidth-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] AccMin = {1'b1, {(AccWidth-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

    state_t                     state_q, state_d;
    logic                       latch_cfg;
    logic                       accept;
    logic [AddrWidth:0]         cfg_pix_q;
    logic [7:0]                 cfg_grp_q;
    logic signed [AccWidth-1:0] bias_q;
    logic [AddrWidth:0]         pix_cnt;
    logic [7:0]                 grp_cnt;
    logic [7:0]                 drain_cnt;
    logic                       first_pass, final_pass, last_pix;

    // Beat pipeline: stage i holds the beat accepted i edges ago, aligned with tree level L-1-i.
    logic                       pipe_vld   [0:L-1];
    logic [AddrWidth-1:0]       pipe_pix   [0:L-1];
    logic                       pipe_first [0:L-1];
    logic                       pipe_final [0:L-1];
    logic signed [AccWidth-1:0] psum_pipe  [0:L-1];

    // Adder tree as a heap: node k sums operands 2k and 2k+1; operands >= InputDim are channels.
    logic signed [AccWidth-1:0] node_q  [1:InputDim-1];
    logic signed [AccWidth-1:0] operand [2:2*InputDim-1];

    logic signed [AccWidth-1:0] psum_mem [0:(2**AddrWidth)-1];

    logic                       fin_vld;
    logic                       fin_final;
    logic [AddrWidth-1:0]       fin_pix;
    logic signed [AccWidth-1:0] fin_sum;
    logic signed [AccWidth-1:0] add_base;
    logic signed [AccWidth:0]   sum_wide;
    logic signed [AccWidth-1:0] sum_sat;
    logic signed [AccWidth-1:0] sum_push;
    logic                       sat_hit;

    logic [CntW:0]              inflight;
    logic                       room;
    logic                       pipe_idle;
    logic [CntW-1:0]            fifo_cnt;
    logic [AccWidth-1:0]        fifo_dat;

    assign accept     = in_valid && in_ready;
    assign first_pass = (grp_cnt == 8'd0);
    assign final_pass = (grp_cnt == cfg_grp_q - 8'd1);
    assign last_pix   = (pix_cnt == cfg_pix_q - PixOne);
    assign busy       = (state_q != IDLE);

    // Beats in flight between acceptance and the FIFO push, used for final-pass admission.
    always_comb begin
        inflight = (CntW+1)'(fin_vld);
        for (int i = 0; i < L; i++) inflight = inflight + (CntW+1)'(pipe_vld[i]);
        pipe_idle = (inflight == '0);
        room      = (({1'b0, fifo_cnt} + inflight) < (CntW+1)'(OutFifoDepth));
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state, in_ready and done.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        done      = 1'b0;
        latch_cfg = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    latch_cfg = 1'b1;
                    state_d   = (cfg_pixels == '0 || cfg_groups == 8'd0) ? FLUSH : RUN;
                end
            end
            RUN: begin
                in_ready = !final_pass || room;
                if (accept && last_pix) state_d = final_pass ? FLUSH : DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == 8'(L)) state_d = RUN;
            end
            FLUSH: begin
                if (pipe_idle && fifo_cnt == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Job configuration, pixel/pass counters and the pass-boundary drain timer.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cfg_pix_q <= '0;
            cfg_grp_q <= '0;
            bias_q    <= '0;
            pix_cnt   <= '0;
            grp_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            if (latch_cfg) begin
                cfg_pix_q <= cfg_pixels;
                cfg_grp_q <= cfg_groups;
                bias_q    <= bias_in;
                pix_cnt   <= '0;
                grp_cnt   <= '0;
            end else if (accept) begin
                if (last_pix) begin
                    pix_cnt <= '0;
                    grp_cnt <= grp_cnt + 8'd1;
                end else begin
                    pix_cnt <= pix_cnt + PixOne;
                end
            end
            drain_cnt <= (state_q == DRAIN) ? drain_cnt + 8'd1 : 8'd0;
        end
    end

    // Valid bits of the beat pipeline and the final-sum stage.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < L; i++) pipe_vld[i] <= 1'b0;
            fin_vld <= 1'b0;
        end else begin
            pipe_vld[0] <= accept;
            for (int i = 1; i < L; i++) pipe_vld[i] <= pipe_vld[i-1];
            fin_vld <= pipe_vld[L-1];
        end
    end

    // Tree operands: sign-extended channels at the leaves, registered nodes above them.
    always_comb begin
        for (int k = 2; k < InputDim; k++) operand[k] = node_q[k];
        for (int i = 0; i < InputDim; i++)
            operand[InputDim+i] = {{(AccWidth-DataWidth){in_data[i*DataWidth+DataWidth-1]}},
                                   in_data[i*DataWidth +: DataWidth]};
    end

    // Final stage: bias on the first pass, buffered partial sum otherwise, saturated to AccWidth.
    always_comb begin
        add_base = pipe_first[L-1] ? bias_q : psum_pipe[L-1];
        sum_wide = {node_q[1][AccWidth-1], node_q[1]} + {add_base[AccWidth-1], add_base};
        sat_hit  = (sum_wide[AccWidth] != sum_wide[AccWidth-1]);
        sum_sat  = sat_hit ? (sum_wide[AccWidth] ? AccMin : AccMax) : sum_wide[AccWidth-1:0];
`ifdef CONV_PSUM_RELU_EN
        sum_push = (pipe_final[L-1] && sum_sat[AccWidth-1]) ? '0 : sum_sat;
`else
        sum_push = sum_sat;
`endif
    end

    // Datapath registers: tree nodes, beat sideband, buffer read (issued at acceptance) and final sum.
    always_ff @(posedge Clk) begin
        for (int k = 1; k < InputDim; k++) node_q[k] <= operand[2*k] + operand[2*k+1];
        pipe_pix[0]   <= pix_cnt[AddrWidth-1:0];
        pipe_first[0] <= first_pass;
        pipe_final[0] <= final_pass;
        psum_pipe[0]  <= psum_mem[pix_cnt[AddrWidth-1:0]];
        for (int i = 1; i < L; i++) begin
            pipe_pix[i]   <= pipe_pix[i-1];
            pipe_first[i] <= pipe_first[i-1];
            pipe_final[i] <= pipe_final[i-1];
            psum_pipe[i]  <= psum_pipe[i-1];
        end
        fin_sum   <= sum_push;
        fin_pix   <= pipe_pix[L-1];
        fin_final <= pipe_final[L-1];
    end

    // Non-final passes write back to the pixel's buffer slot; the final pass leaves it alone.
    always_ff @(posedge Clk) begin
        if (fin_vld && !fin_final) psum_mem[fin_pix] <= fin_sum;
    end

    // Sticky saturation flag, cleared by a new job.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                         ovf <= 1'b0;
        else if (latch_cfg)                 ovf <= 1'b0;
        else if (pipe_vld[L-1] && sat_hit)  ovf <= 1'b1;
    end

    conv_psum_fifo #(
        .Width (AccWidth),
        .Depth (OutFifoDepth),
        .CntW  (CntW)
    ) u_out_fifo (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .wr_vld (fin_vld && fin_final),
        .wr_dat (fin_sum),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (fifo_dat),
        .cnt    (fifo_cnt)
    );

    assign out_data = out_valid ? fifo_dat : '0;
endmodule

// File: tb/tb_conv_psum_acc.sv
// Purpose: directed self-checking bench for conv_psum_acc (default parameters).
// Latency: checks acceptance-to-out_valid timing and pass-boundary stall length.
// Backpressure: exercises out_ready held low on the final pass and release.
module tb_conv_psum_acc;
    logic               Clk = 1'b0;
    logic               Rst_n = 1'b0;
    logic               start = 1'b0;
    logic [12:0]        cfg_pixels = '0;
    logic [7:0]         cfg_groups = '0;
    logic signed [39:0] bias_in = '0;
    logic [127:0]       in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [39:0] out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               busy;
    logic               done;
    logic               ovf;

    localparam longint AccMax = 64'sd549755813887;

    conv_psum_acc dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .start      (start),
        .cfg_pixels (cfg_pixels),
        .cfg_groups (cfg_groups),
        .bias_in    (bias_in),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Output collector and event monitor, sampled just after the falling edge.
    logic signed [39:0] got[$];
    int   done_cnt = 0;
    int   ov_rise = -1;
    logic ov_prev = 1'b0;
    always @(negedge Clk) begin
        #1;
        if (out_valid && out_ready) got.push_back(out_data);
        if (done) done_cnt = done_cnt + 1;
        if (out_valid && !ov_prev) ov_rise = cyc;
        ov_prev = out_valid;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [12:0] pix, input logic [7:0] grp, input logic signed [39:0] bias);
        cfg_pixels = pix;
        cfg_groups = grp;
        bias_in    = bias;
        start      = 1'b1;
        @(negedge Clk);
        start      = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = {8{v}};
        while (!in_ready && t < 200) begin
            @(negedge Clk);
            t++;
        end
        check("accept", longint'(in_ready), 1);
        @(negedge Clk);
        in_valid = 1'b0;
    endtask

    task automatic drain_low(output int n);
        n = 0;
        while (!in_ready && n < 50) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 400) begin
            @(negedge Clk);
            t++;
        end
        check(tag, longint'(done), 1);
        @(negedge Clk);
    endtask

    task automatic check_out(input string tag, input int base, input int idx, input longint exp);
        if (base + idx < got.size()) check(tag, longint'(got[base+idx]), exp);
        else check(tag, -1, exp);
    endtask

    initial begin
        int base, dbase, acc_cyc, n, acc;
        repeat (3) @(negedge Clk);
        check("reset_ctl", longint'({in_ready, out_valid, busy, done, ovf}), 0);
        check("reset_data", longint'(out_data), 0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Single pass: 8 channels of 1 plus bias 10, with push timing.
        base = got.size(); dbase = done_cnt;
        start_job(13'd4, 8'd1, 40'sd10);
        check("t1_busy", longint'(busy), 1);
        acc_cyc = cyc;
        for (int i = 0; i < 4; i++) send(16'd1);
        wait_done("t1_done");
        check("t1_latency", longint'(ov_rise - acc_cyc), 5);
        check("t1_count", longint'(got.size() - base), 4);
        for (int i = 0; i < 4; i++) check_out("t1_out", base, i, 18);
        check("t1_done_once", longint'(done_cnt - dbase), 1);
        check("t1_idle", longint'(busy), 0);

        // Empty job: done the cycle after start, no output.
        base = got.size();
        start_job(13'd0, 8'd3, 40'sd0);
        check("empty_done", longint'({busy, done}), 3);
        @(negedge Clk);
        check("empty_idle", longint'({busy, done}), 0);
        check("empty_no_out", longint'(got.size() - base), 0);

        // Three passes of 1, 2, 3 per channel: 8+16+24 = 48 per pixel.
        base = got.size();
        start_job(13'd2, 8'd3, 40'sd0);
        send(16'd1); send(16'd1);
        drain_low(n);
        check("t2_gap0", longint'(n), 4);
        send(16'd2); send(16'd2);
        drain_low(n);
        check("t2_gap1", longint'(n), 4);
        send(16'd3); send(16'd3);
        wait_done("t2_done");
        check("t2_count", longint'(got.size() - base), 2);
        for (int i = 0; i < 2; i++) check_out("t2_out", base, i, 48);

        // Saturation across four passes.
        base = got.size();
        start_job(13'd1, 8'd4, 40'sd549755813887);
        for (int g = 0; g < 4; g++) begin
            send(16'd1);
            if (g < 3) drain_low(n);
        end
        wait_done("t3_done");
        check_out("t3_out", base, 0, AccMax);
        repeat (3) @(negedge Clk);
        check("t3_ovf_sticky", longint'(ovf), 1);

        // Final-pass backpressure: out_ready low, admission must stop at FIFO depth.
        base = got.size();
        start_job(13'd12, 8'd1, 40'sd0);
        check("t4_ovf_clear", longint'(ovf), 0);
        out_ready = 1'b0;
        acc = 0;
        for (int p = 0; p < 12; p++) begin
            int t;
            t = 0;
            in_valid = 1'b1;
            in_data  = {8{16'(p + 1)}};
            while (!in_ready && t < 30) begin
                @(negedge Clk);
                t++;
            end
            if (!in_ready) break;
            @(negedge Clk);
            acc++;
        end
        check("t4_accepted", longint'(acc), 8);
        check("t4_held", longint'(out_valid), 1);
        check("t4_none_out", longint'(got.size() - base), 0);
        out_ready = 1'b1;
        for (int p = acc; p < 12; p++) send(16'(p + 1));
        in_valid = 1'b0;
        wait_done("t4_done");
        check("t4_count", longint'(got.size() - base), 12);
        for (int i = 0; i < 12; i++) check_out("t4_out", base, i, 8 * (i + 1));

        // Negative final sum: clamped only when the ReLU option is built in.
        base = got.size();
        start_job(13'd1, 8'd1, -40'sd100);
        send(16'd1);
        wait_done("t5_done");
`ifdef CONV_PSUM_RELU_EN
        check_out("t5_relu", base, 0, 0);
`else
        check_out("t5_relu", base, 0, -92);
`endif
        // Negative intermediate pass stays negative; -92 + 96 = 4 either way.
        base = got.size();
        start_job(13'd1, 8'd2, -40'sd100);
        send(16'd1);
        drain_low(n);
        send(16'd12);
        wait_done("t5b_done");
        check_out("t5b_out", base, 0, 4);

        // Reset during pass 1, then a clean job with an ignored start in the middle.
        start_job(13'd2, 8'd2, 40'sd0);
        send(16'd1); send(16'd1);
        drain_low(n);
        send(16'd5);
        check("t6_busy_pre", longint'(busy), 1);
        #2 Rst_n = 1'b0;
        #1;
        check("t6_rst_ctl", longint'({in_ready, out_valid, busy, done, ovf}), 0);
        check("t6_rst_data", longint'(out_data), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        base = got.size(); dbase = done_cnt;
        start_job(13'd2, 8'd1, 40'sd5);
        start_job(13'd0, 8'd0, 40'sd0);
        check("t6_start_ignored", longint'(busy), 1);
        send(16'd2); send(16'd2);
        wait_done("t6_done");
        check("t6_count", longint'(got.size() - base), 2);
        for (int i = 0; i < 2; i++) check_out("t6_out", base, i, 21);
        check("t6_done_once", longint'(done_cnt - dbase), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv_psum_acc.md
CONV_PSUM_ACC -- requirements
Module: conv_psum_acc

Interface
REQ-001 SHALL have parameters: DataWidth, 16, signed width of one channel partial sum; InputDim, 8, channels reduced per beat (power of two, >=2); AccWidth, 40, accumulator and output width; AddrWidth, 12, partial-sum buffer address width (depth 2**AddrWidth pixels); OutFifoDepth, 8, output FIFO entries (must exceed log2(InputDim)+2).
REQ-002 SHALL have ports: Clk in 1 clock; Rst_n in 1 asynchronous active-low reset; one clock, and reset is asynchronous and active-low.
REQ-003 SHALL have ports: start in 1 job start pulse; cfg_pixels in AddrWidth+1 pixels per pass; cfg_groups in 8 number of passes (input-channel groups); bias_in in AccWidth signed bias.
REQ-004 SHALL have ports: in_data in InputDim*DataWidth signed beats, channel i at [i*DataWidth +: DataWidth]; in_valid in 1; in_ready out 1.
REQ-005 SHALL have ports: out_data out AccWidth signed result; out_valid out 1; out_ready in 1; busy out 1; done out 1 one-cycle pulse; ovf out 1 sticky saturation flag.

Function
REQ-006 SHALL accept a beat on the cycle where in_valid and in_ready are both high; beats within a pass are pixels 0..cfg_pixels-1 in order, with passes 0..cfg_groups-1 following in sequence.
REQ-007 SHALL reduce each beat's InputDim channels, sign-extended to AccWidth, through a registered adder tree of L=log2(InputDim) stages.
REQ-008 SHALL add, in one further registered stage, bias_in on pass 0 or the buffered partial sum of the same pixel on later passes, saturating to signed AccWidth and setting ovf on saturation.
REQ-009 SHALL write the stage-L+1 sum to buffer address = pixel index on non-final passes; on the final pass it SHALL push the sum to the output FIFO and leave the buffer unchanged.
REQ-010 SHALL issue the buffer read at beat acceptance so read data aligns with the tree output; latency from acceptance to FIFO push is L+1 clock edges, and out_valid rises the following cycle when the FIFO was empty.
REQ-011 SHALL use FSM states IDLE, RUN, DRAIN and FLUSH: start in IDLE latches cfg and bias, clears ovf, and goes to RUN; the last beat of a non-final pass goes to DRAIN; DRAIN lasts L+1 cycles with in_ready low, then returns to RUN; the last beat of the final pass goes to FLUSH; FLUSH exits to IDLE with a done pulse when the pipeline and FIFO are empty.
REQ-012 SHALL drive in_ready high only in RUN, and on the final pass only when FIFO occupancy plus in-flight beats is less than OutFifoDepth, so no result is ever dropped.
REQ-013 SHALL present out_data from the FIFO head; an entry pops when out_valid and out_ready are both high; a push and a pop in the same cycle SHALL keep occupancy constant.
REQ-014 SHALL treat cfg_groups==1 as a single final pass (bias+tree emitted directly), and SHALL treat cfg_pixels==0 or cfg_groups==0 as an empty job that pulses done one cycle after start with no output.
REQ-015 SHALL ignore start while busy is high; busy is high in every state except IDLE.

Reset
REQ-016 SHALL, on Rst_n low at any time including mid-job, return the FSM to IDLE, empty the FIFO and pipeline, and drive in_ready, out_valid, busy, done and ovf to 0 and out_data to 0; buffer contents are not cleared.

Configuration
REQ-017 SHALL support macro CONV_PSUM_RELU_EN: when defined, final-pass sums below 0 are replaced by 0 before the FIFO push; when undefined, sums pass unmodified; non-final passes are unaffected in both cases.

Verification
REQ-018 Cover: InputDim=8, groups=1, pixels=4, bias=10, all channels=1 -> outputs 18,18,18,18 then done; first out_valid 5 cycles after first acceptance.
REQ-019 Cover: groups=3, pixels=2, bias=0, pass values channel=1,2,3 -> outputs 48,48; in_ready low 4 cycles at each pass boundary.
REQ-020 Cover: pixels=1, groups=4, channels=AccWidth-saturating inputs (bias=2**39-1, channel=+1) -> output 2**39-1 and ovf=1 until next start.
REQ-021 Cover: final pass with out_ready held low -> in_ready drops after at most OutFifoDepth pushes, no loss; release -> all results out in order.
REQ-022 Cover: Rst_n asserted mid-pass 1 -> all outputs 0 the same cycle; new start with groups=1 runs correctly; start pulsed while busy -> no effect.
REQ-023 Cover: CONV_PSUM_RELU_EN defined, bias=-100, channels=1 -> output 0; undefined -> output -92.
